// File: rtl/lab3_bcd_collector.sv
// lab3_bcd_collector: rebuilds BCD digits from a serial bit stream that arrives LSB first, then packs them into words.
// Latency: Digit and Bcd_word update on the edge that samples the 4th bit of a digit, so they are visible one cycle after that bit.
// Backpressure: a finished word is held until Word_ack. A word that finishes while the previous one is still held is dropped and sets Overflow.
//
// Ports:
//   Clk, Rst                   clock; asynchronous active-high reset
//   Bit_en, Z_in               serial BCD bit, qualified by Bit_en
//   Frame_start                realign; any partial digit is discarded
//   Word_ack                   consumer accepts the held Bcd_word
//   Digit/Digit_valid/Digit_err  last completed digit, one-cycle pulses
//   Bcd_word/Word_valid/Word_err held word, first digit in the top nibble
//   Overflow                   sticky; a completed word was dropped
module lab3_bcd_collector #(
  parameter int NDIGITS = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Bit_en,
  input  logic                 Z_in,
  input  logic                 Frame_start,
  input  logic                 Word_ack,
  output logic [3:0]           Digit,
  output logic                 Digit_valid,
  output logic                 Digit_err,
  output logic [4*NDIGITS-1:0] Bcd_word,
  output logic                 Word_valid,
  output logic                 Word_err,
  output logic                 Overflow
);

  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DW-1:0] DLAST = DW'(NDIGITS - 1);

  logic [1:0]           r_bcnt;
  logic [2:0]           r_sh;
  logic [DW-1:0]        r_dcnt;
  logic [4*NDIGITS-1:0] r_acc;
  logic                 r_aerr;

  // Frame_start takes effect in the same cycle, so a bit that arrives
  // with it is treated as bit 0 of a fresh digit.
  logic [1:0]           w_bcnt_eff;
  logic [2:0]           w_sh_eff;
  logic [3:0]           w_d;
  logic                 w_d_bad;
  logic                 w_dig_done;
  logic                 w_word_done;
  logic [4*NDIGITS+3:0] w_acc_wide;
  logic [4*NDIGITS-1:0] w_acc_next;
  logic                 w_aerr_next;

  assign w_bcnt_eff  = Frame_start ? 2'd0 : r_bcnt;
  assign w_sh_eff    = Frame_start ? 3'd0 : r_sh;
  assign w_d         = {Z_in, w_sh_eff};
  assign w_d_bad     = (w_d > 4'd9);
  assign w_dig_done  = Bit_en && (w_bcnt_eff == 2'd3);
  assign w_word_done = w_dig_done && (r_dcnt == DLAST);
  // Shift the new digit in at the bottom. The wide temporary avoids a
  // zero-width slice when NDIGITS is 1.
  assign w_acc_wide  = {r_acc, w_d};
  assign w_acc_next  = w_acc_wide[4*NDIGITS-1:0];
  assign w_aerr_next = r_aerr | w_d_bad;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bcnt      <= 2'd0;
      r_sh        <= 3'd0;
      r_dcnt      <= '0;
      r_acc       <= '0;
      r_aerr      <= 1'b0;
      Digit       <= 4'd0;
      Digit_valid <= 1'b0;
      Digit_err   <= 1'b0;
      Bcd_word    <= '0;
      Word_valid  <= 1'b0;
      Word_err    <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      Digit_valid <= 1'b0;
      Digit_err   <= 1'b0;

      // Bit path
      if (Frame_start) begin
        r_bcnt <= 2'd0;
        r_sh   <= 3'd0;
      end
      if (Bit_en) begin
        if (w_dig_done) begin
          Digit       <= w_d;
          Digit_valid <= 1'b1;
          Digit_err   <= w_d_bad;
          r_bcnt      <= 2'd0;
        end else begin
          r_sh   <= {Z_in, w_sh_eff[2:1]};
          r_bcnt <= w_bcnt_eff + 2'd1;
        end
      end

      // Word accumulation
      if (w_dig_done) begin
        if (r_dcnt == DLAST) begin
          r_dcnt <= '0;
          r_acc  <= '0;
          r_aerr <= 1'b0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
          r_acc  <= w_acc_next;
          r_aerr <= w_aerr_next;
        end
      end

      // Output handshake. A new word may replace the held one in the same
      // cycle that the held one is acked.
      if (w_word_done) begin
        if (!Word_valid || Word_ack) begin
          Bcd_word   <= w_acc_next;
          Word_err   <= w_aerr_next;
          Word_valid <= 1'b1;
        end else begin
          Overflow <= 1'b1;
        end
      end else if (Word_valid && Word_ack) begin
        Word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lab3_bcd_collector.sv
// tb_lab3_bcd_collector: scoreboard bench for lab3_bcd_collector with NDIGITS=4.
// Latency: expected values are checked at the negative clock edge, or #1 after the rising edge.
// Backpressure: the bench drives Word_ack to exercise holding, overflow, and an ack that coincides with a new word.
module tb_lab3_bcd_collector;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Bit_en = 1'b0;
  logic        Z_in = 1'b0;
  logic        Frame_start = 1'b0;
  logic        Word_ack = 1'b0;
  logic [3:0]  Digit;
  logic        Digit_valid;
  logic        Digit_err;
  logic [15:0] Bcd_word;
  logic        Word_valid;
  logic        Word_err;
  logic        Overflow;

  int n_checks = 0;
  int n_errors = 0;
  int dv_cnt   = 0;

  logic [4:0]  dig_q[$];   // {err, digit}
  logic [16:0] word_q[$];  // {err, word}

  lab3_bcd_collector #(.NDIGITS(4)) dut (
    .Clk(Clk), .Rst(Rst), .Bit_en(Bit_en), .Z_in(Z_in),
    .Frame_start(Frame_start), .Word_ack(Word_ack),
    .Digit(Digit), .Digit_valid(Digit_valid), .Digit_err(Digit_err),
    .Bcd_word(Bcd_word), .Word_valid(Word_valid), .Word_err(Word_err),
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor
  logic seen_word   = 1'b0;
  logic ack_pending = 1'b0;
  always @(negedge Clk) begin
    logic [4:0]  de;
    logic [16:0] we;
    if (Digit_valid) begin
      dv_cnt++;
      if (dig_q.size() == 0) begin
        chk("unexpected_digit", {27'd0, Digit_err, Digit}, 32'hFFFF_FFFF);
      end else begin
        de = dig_q.pop_front();
        chk("digit", {28'd0, Digit}, {28'd0, de[3:0]});
        chk("digit_err", {31'd0, Digit_err}, {31'd0, de[4]});
      end
    end else begin
      chk("digit_err_no_valid", {31'd0, Digit_err}, 32'd0);
    end
    if (ack_pending || !Word_valid || Rst) seen_word = 1'b0;
    if (Word_valid && !seen_word) begin
      seen_word = 1'b1;
      if (word_q.size() == 0) begin
        chk("unexpected_word", {15'd0, Word_err, Bcd_word}, 32'hFFFF_FFFF);
      end else begin
        we = word_q.pop_front();
        chk("word", {16'd0, Bcd_word}, {16'd0, we[15:0]});
        chk("word_err", {31'd0, Word_err}, {31'd0, we[16]});
      end
    end
    // Inputs stay stable until the next rising edge, so this reflects that edge.
    ack_pending = Word_ack && Word_valid && !Rst;
  end

  task automatic cyc(input logic en, input logic z, input logic fs, input logic ack);
    Bit_en = en; Z_in = z; Frame_start = fs; Word_ack = ack;
    @(posedge Clk); #1;
    Bit_en = 1'b0; Z_in = 1'b0; Frame_start = 1'b0; Word_ack = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d, input logic fs, input int maxgap, input logic ack_last);
    dig_q.push_back({(d > 4'd9), d});
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int k = 0; k < g; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, d[i], fs && (i == 0), ack_last && (i == 3));
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int maxgap, input logic ack_last, input logic expect_accept);
    logic e;
    e = 1'b0;
    for (int j = 3; j >= 0; j--) if (w[4*j +: 4] > 4'd9) e = 1'b1;
    if (expect_accept) word_q.push_back({e, w});
    for (int j = 3; j >= 0; j--) send_digit(w[4*j +: 4], 1'b1, maxgap, ack_last && (j == 0));
  endtask

  task automatic pulse_reset;
    Rst = 1'b1;
    #2;
    chk("rst_async_digit_valid", {31'd0, Digit_valid}, 32'd0);
    chk("rst_async_word_valid", {31'd0, Word_valid}, 32'd0);
    chk("rst_async_overflow", {31'd0, Overflow}, 32'd0);
    chk("rst_async_bcd_word", {16'd0, Bcd_word}, 32'd0);
    #1 Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] rw;
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_digit", {28'd0, Digit}, 32'd0);
    chk("rst_digit_valid", {31'd0, Digit_valid}, 32'd0);
    chk("rst_word", {16'd0, Bcd_word}, 32'd0);
    chk("rst_word_valid", {31'd0, Word_valid}, 32'd0);
    chk("rst_word_err", {31'd0, Word_err}, 32'd0);
    chk("rst_overflow", {31'd0, Overflow}, 32'd0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // 1: reset mid-digit, then a fresh digit of 9
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reset();
    base = dv_cnt;
    send_digit(4'd9, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_digit_hold", {28'd0, Digit}, 32'd9);
    chk("t1_dv_count", dv_cnt - base, 32'd1);
    pulse_reset();

    // 2: word 1234, one bit per cycle
    base = dv_cnt;
    send_word(16'h1234, 0, 1'b0, 1'b1);
    chk("t2_word_valid_latency", {31'd0, Word_valid}, 32'd1);
    chk("t2_word_now", {16'd0, Bcd_word}, 32'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_dv_count", dv_cnt - base, 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_ack_clears", {31'd0, Word_valid}, 32'd0);

    // 3: digit 10 is flagged
    send_word(16'hA000, 0, 1'b0, 1'b1);
    chk("t3_word_err_now", {31'd0, Word_err}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ack_clears", {31'd0, Word_valid}, 32'd0);

    // 4: Frame_start discards two partial bits
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_digit(4'd3, 1'b1, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_digit", {28'd0, Digit}, 32'd3);
    pulse_reset();

    // 5: hold, overflow, ack coincident with a new word
    send_word(16'h1234, 0, 1'b0, 1'b1);
    chk("t5_ovf_before", {31'd0, Overflow}, 32'd0);
    send_word(16'h5678, 0, 1'b0, 1'b0);
    chk("t5_word_held", {16'd0, Bcd_word}, 32'h1234);
    chk("t5_overflow", {31'd0, Overflow}, 32'd1);
    chk("t5_still_valid", {31'd0, Word_valid}, 32'd1);
    send_word(16'h9876, 0, 1'b1, 1'b1);
    chk("t5_ack_plus_new_valid", {31'd0, Word_valid}, 32'd1);
    chk("t5_ack_plus_new_word", {16'd0, Bcd_word}, 32'h9876);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_ack_clears", {31'd0, Word_valid}, 32'd0);
    chk("t5_overflow_sticky", {31'd0, Overflow}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_reset();

    // 6: Bit_en gaps
    base = dv_cnt;
    send_digit(4'd7, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_digit", {28'd0, Digit}, 32'd7);
    chk("t6_dv_count", dv_cnt - base, 32'd1);
    pulse_reset();

    // Random words with gaps, acked after each
    for (int r = 0; r < 4; r++) begin
      rw = 16'($urandom);
      send_word(rw, 2, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rand_ack_clears", {31'd0, Word_valid}, 32'd0);
    end

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("digit_q_drained", dig_q.size(), 32'd0);
    chk("word_q_drained", word_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lab3_bcd_collector.md
Name: lab3_bcd_collector

Overview:
- Downstream stage of the serial Excess-3-to-BCD converter.
- Samples the converter's serial BCD output (LSB first, 4 bits per digit) and reassembles parallel digits.
- Packs NDIGITS digits into a BCD word, most significant digit first, and presents the word with a valid/ack handshake.
- Flags non-BCD digits and dropped words.

Parameters:
NDIGITS, 4, number of BCD digits per output word (>=1)

Ports:
Clk  input  1  system clock, rising-edge active
Rst  input  1  asynchronous, active-high reset
Bit_en  input  1  Z_in carries a valid serial bit this cycle
Z_in  input  1  serial BCD bit from converter, digit LSB first
Frame_start  input  1  realign: discard any partial digit (issued with each converter digit reset)
Word_ack  input  1  consumer accepts Bcd_word this cycle
Digit  output  4  last completed digit (registered)
Digit_valid  output  1  one-cycle pulse: Digit updated
Digit_err  output  1  one-cycle pulse with Digit_valid when Digit > 9
Bcd_word  output  4*NDIGITS  packed word; first-received digit in [4*NDIGITS-1 -: 4]
Word_valid  output  1  Bcd_word/Word_err valid, held until acked
Word_err  output  1  some digit of the held word was > 9
Overflow  output  1  sticky: a completed word was dropped; cleared only by Rst

Behaviour:
- Reset (async, Rst=1): bit counter, digit counter, shift/accumulator registers cleared; all outputs 0. Effective immediately, mid-digit or mid-handshake included; a held word is lost.
- Bit path: 2-bit counter bcnt, 3-bit partial shift sh. On a rising edge with Bit_en=1, Z_in is sampled.
  - bcnt<3: sh <= {Z_in, sh[2:1]}; bcnt++.
  - bcnt==3: digit d = {Z_in, sh}; Digit <= d; Digit_valid <= 1; Digit_err <= (d>9); bcnt <= 0.
- Digit_valid and Digit_err are 1 only in the cycle after the completing edge, else 0. Digit holds its value.
- Bit_en=0: no state change in the bit path.
- Frame_start=1 at an edge: bcnt and sh cleared. If Bit_en=1 in the same cycle, Z_in is taken as bit 0 of a new digit (bcnt <= 1). Frame_start does not touch the digit counter or the held word.
- Word path: accumulator acc (4*NDIGITS bits), digit counter dcnt (0..NDIGITS-1), error flag aerr.
  - On each completed digit: acc <= {acc[4*NDIGITS-5:0], d}; aerr |= (d>9).
  - When dcnt==NDIGITS-1, the word completes: dcnt <= 0, acc/aerr cleared. Otherwise dcnt++.
- Word completion with Word_valid=0, or with Word_valid=1 and Word_ack=1 in the same cycle: Bcd_word <= completed word; Word_err <= aerr|(d>9); Word_valid <= 1.
- Word completion with Word_valid=1 and Word_ack=0: completed word discarded; Bcd_word/Word_err unchanged; Overflow <= 1.
- Word_ack=1 with Word_valid=1 and no completion: Word_valid <= 0 at that edge. Word_ack while Word_valid=0 is ignored.
- Latency: Bcd_word/Word_valid appear at the same edge the last digit's 4th bit is sampled, i.e. visible one cycle after that bit.
- Bcd_word is stable while Word_valid=1, except on a simultaneous ack plus new word.
- Implementation is fully synchronous to Clk apart from Rst.

Test Plan:
1. Reset mid-digit → all outputs 0; next 4 bits form a fresh digit.
   - Stimulus: Rst=1, Bit_en=1 for 2 bits, Rst pulse, then 4 bits 1,0,0,1.
   - Response: Digit=9, Digit_valid pulse, Digit_err=0.
2. Word assembly (NDIGITS=4), LSB first, 1 bit/cycle, Frame_start before each digit.
   - Stimulus: digits 1,2,3,4.
   - Response: Bcd_word=16'h1234, Word_valid=1 one cycle after the 16th bit, Word_err=0; exactly four Digit_valid pulses.
3. Error flagging.
   - Stimulus: digit bits 0,1,0,1 (value 10), then digits 0,0,0.
   - Response: Digit_err pulse on the first digit; Bcd_word=16'hA000, Word_err=1.
4. Frame_start realignment.
   - Stimulus: 2 bits, then Frame_start with bit 1, then bits 1,0,0.
   - Response: Digit=3; the partial bits are discarded.
5. Handshake and overflow.
   - Stimulus: hold Word_ack=0 and send words 16'h1234 and 16'h5678.
   - Response: Bcd_word stays 16'h1234, Overflow=1.
   - Then: Word_ack=1 coincident with completion of 16'h9876 → Bcd_word=16'h9876, Word_valid stays 1. Next-cycle Word_ack → Word_valid=0.
6. Bit_en gaps.
   - Stimulus: digit 7 sent with Bit_en low for random 0–3 cycles between bits.
   - Response: Digit=7, single Digit_valid pulse.
